// File: rtl/gate_level_full_adder.sv
// gate_level_full_adder: registered 1-bit full adder built from 2-input NAND cells, with valid qualifier
module nand2_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module gate_level_full_adder #(
  parameter bit NAND_ONLY = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic l,
  output logic h,
  output logic out_valid
);
  logic l_next, h_next;
  generate
    if (NAND_ONLY) begin : g_nand
      logic n1, n2, n3, x, n5, n6, n7;
      nand2_cell u_n1 (.a(a),  .b(b),  .y(n1));
      nand2_cell u_n2 (.a(a),  .b(n1), .y(n2));
      nand2_cell u_n3 (.a(b),  .b(n1), .y(n3));
      nand2_cell u_x  (.a(n2), .b(n3), .y(x));
      nand2_cell u_n5 (.a(x),  .b(c),  .y(n5));
      nand2_cell u_n6 (.a(x),  .b(n5), .y(n6));
      nand2_cell u_n7 (.a(c),  .b(n5), .y(n7));
      nand2_cell u_l  (.a(n6), .b(n7), .y(l_next));
      nand2_cell u_h  (.a(n1), .b(n5), .y(h_next));
    end else begin : g_beh
      assign l_next = a ^ b ^ c;
      assign h_next = (a & b) | (c & (a ^ b));
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      l <= 1'b0;
      h <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        l <= l_next;
        h <= h_next;
      end
    end
  end
endmodule

// File: tb/tb_gate_level_full_adder.sv
// tb_gate_level_full_adder: random and directed checks of both core variants plus a two-cell ripple
module tb_gate_level_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic l_n, h_n, v_n, l_b, h_b, v_b;
  logic r0v = 1'b0, r0a = 1'b0, r0b = 1'b0, r0c = 1'b0;
  logic r1v = 1'b0, r1a = 1'b0, r1b = 1'b0;
  logic r0l, r0h, r0o, r1l, r1h, r1o;
  logic m_v;
  logic [1:0] m_sum;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_level_full_adder #(.NAND_ONLY(1'b1)) u_nand (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .l(l_n), .h(h_n), .out_valid(v_n)
  );
  gate_level_full_adder #(.NAND_ONLY(1'b0)) u_beh (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .l(l_b), .h(h_b), .out_valid(v_b)
  );
  gate_level_full_adder u_r0 (
    .clk(clk), .rst(rst), .in_valid(r0v), .a(r0a), .b(r0b), .c(r0c),
    .l(r0l), .h(r0h), .out_valid(r0o)
  );
  gate_level_full_adder u_r1 (
    .clk(clk), .rst(rst), .in_valid(r1v), .a(r1a), .b(r1b), .c(r0h),
    .l(r1l), .h(r1h), .out_valid(r1o)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Model: outputs are the arithmetic sum of the last captured inputs, cleared by reset.
  task automatic step(input logic r, input logic v, input logic [2:0] abc, input string tag);
    rst = r;
    in_valid = v;
    {a, b, c} = abc;
    @(posedge clk);
    if (r) begin
      m_v = 1'b0;
      m_sum = 2'd0;
    end else begin
      m_v = v;
      if (v) m_sum = 2'(abc[2]) + 2'(abc[1]) + 2'(abc[0]);
    end
    @(negedge clk);
    check({tag, "_nand"}, {1'b0, v_n, h_n, l_n}, {1'b0, m_v, m_sum});
    check({tag, "_beh"}, {1'b0, v_b, h_b, l_b}, {1'b0, m_v, m_sum});
  endtask

  task automatic ripple(input logic [1:0] ra, input logic [1:0] rb, input logic rc);
    r0v = 1'b1;
    {r0a, r0b, r0c} = {ra[0], rb[0], rc};
    @(posedge clk);
    @(negedge clk);
    r0v = 1'b0;
    {r0a, r0b, r0c} = 3'($urandom_range(0, 7));
    r1v = 1'b1;
    {r1a, r1b} = {ra[1], rb[1]};
    @(posedge clk);
    @(negedge clk);
    r1v = 1'b0;
    check("ripple", {r1o, r1h, r1l, r0l}, {1'b1, 3'(ra) + 3'(rb) + 3'(rc)});
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 3'b111, "reset");
    step(1'b1, 1'b1, 3'b111, "reset");
    step(1'b0, 1'b1, 3'b111, "release");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), "sweep");
    step(1'b0, 1'b1, 3'b101, "hold_cap");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), "hold");
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 15) == 0), 1'($urandom), 3'($urandom_range(0, 7)), "rand");
    step(1'b0, 1'b0, 3'b000, "idle");
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) ripple(2'(i >> 3), 2'(i >> 1), 1'(i));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
